// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: N-bit operands, 2N-bit product, one partial
// product per cycle, unsigned or two's-complement selected per operation.
module seq_multiplier #(
   parameter int unsigned N = 8
) (
   input  logic           clk,
   input  logic           resetn,
   input  logic           start,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   input  logic           signed_mode,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] p
);

   localparam int unsigned   CW   = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t         state;
   logic [2*N-1:0] a_sh;
   logic [2*N-1:0] acc;
   logic [2*N-1:0] acc_next;
   logic [N-1:0]   b_sh;
   logic [N-1:0]   a_mag;
   logic [N-1:0]   b_mag;
   logic [CW-1:0]  count;
   logic           neg;

   // -2^(N-1) negates to itself, which read unsigned is exactly its magnitude
   always_comb begin
      a_mag = (signed_mode && a[N-1]) ? -a : a;
      b_mag = (signed_mode && b[N-1]) ? -b : b;
   end

   // a_sh tracks a_mag << count, so the add needs no variable shifter
   always_comb begin
      acc_next = acc + (b_sh[0] ? a_sh : '0);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         p     <= '0;
         acc   <= '0;
         a_sh  <= '0;
         b_sh  <= '0;
         count <= '0;
         neg   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_sh  <= (2*N)'(a_mag);
                  b_sh  <= b_mag;
                  neg   <= signed_mode & (a[N-1] ^ b[N-1]);
                  acc   <= '0;
                  count <= '0;
                  busy  <= 1'b1;
                  state <= CALC;
               end
            end
            CALC: begin
               acc   <= acc_next;
               a_sh  <= a_sh << 1;
               b_sh  <= b_sh >> 1;
               count <= count + CW'(1);
               if (count == LAST) begin
                  p     <= neg ? -acc_next : acc_next;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
